inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, release is sampled on clk.
REQ-004 inst_addr  output  32  fetch address to inst_cache; equals internal PC register.
REQ-005 inst_in  input  32  instruction word from inst_cache for inst_addr.
REQ-006 inst_valid  input  1  inst_in valid for the current inst_addr (hit or refill done).
REQ-007 fence  output  1  one-cycle cache invalidate pulse to inst_cache.
REQ-008 stall_i  input  1  decode not ready; hold IF/ID register and PC.
REQ-009 redirect_i  input  1  one-cycle pulse: branch/jump/exception target valid.
REQ-010 redirect_pc_i  input  32  new fetch address, word aligned.
REQ-011 fence_req_i  input  1  one-cycle pulse from decode (fence.i); always accompanied by redirect_i to the next PC.
REQ-012 if_valid_o  output  1  IF/ID register holds a valid instruction.
REQ-013 if_pc_o  output  32  address of if_inst_o.
REQ-014 if_inst_o  output  32  fetched instruction word.

Function
REQ-015 States: RUN, DRAIN, FENCE; DRAIN/FENCE never capture into IF/ID.
REQ-016 inst_addr SHALL be stable whenever inst_valid=0 (cache miss in progress); PC changes only in cycles with inst_valid=1, or in FENCE.
REQ-017 RUN, inst_valid=1, stall_i=0, no redirect: IF/ID <= {1, PC, inst_in}; PC <= PC+4 (mod 2^32, wrap FFFF_FFFC -> 0000_0000).
REQ-018 RUN, inst_valid=0, no redirect: if_valid_o <= 0 unless stall_i=1 (then IF/ID held); PC held.
REQ-019 RUN, stall_i=1, no redirect: IF/ID and PC held regardless of inst_valid.
REQ-020 Priority each cycle: redirect_i > stall_i > normal advance.
REQ-021 redirect_i in RUN with inst_valid=1 and fence_req_i=0: PC <= redirect_pc_i, if_valid_o <= 0, stay RUN; redirected fetch latency is 1 cycle plus cache latency.
REQ-022 redirect_i in RUN with inst_valid=0: pending_pc <= redirect_pc_i, if_valid_o <= 0, go DRAIN.
REQ-023 DRAIN: inst_addr held; new redirect_i overwrites pending_pc; on inst_valid=1 discard inst_in, PC <= pending_pc, go RUN (or FENCE if fence pending).
REQ-024 fence_req_i with redirect_i: fence_pending <= 1, target latched as in REQ-021/022; with inst_valid=1 go FENCE directly, else via DRAIN.
REQ-025 FENCE: fence=1 for exactly one cycle, PC <= target, fence_pending <= 0, if_valid_o=0, next state RUN.
REQ-026 fence SHALL be 0 in every state except FENCE; never asserted while a refill is outstanding (inst_valid=0).
REQ-027 fence_req_i without redirect_i is ignored.

Reset
REQ-028 On rst=0: PC=inst_addr=RESET_PC, state RUN, if_valid_o=0, if_pc_o=0, if_inst_o=0, fence=0, pending_pc=0, fence_pending=0.
REQ-029 Reset mid-miss or mid-DRAIN discards pending target; first fetch after release is RESET_PC.

Verification
REQ-030 Sequential hits: inst_valid=1, inst_in=addr -> inst_addr 0,4,8,C on consecutive cycles; if_pc_o/if_inst_o 0,4,8 lag one cycle, if_valid_o=1.
REQ-031 Miss: inst_addr=0x10, inst_valid=0 for 4 cycles -> inst_addr held 0x10, if_valid_o=0; inst_valid=1 -> if_pc_o=0x10, inst_addr=0x14 next cycle.
REQ-032 Redirect during miss: inst_addr=0x20 missing, redirect_pc_i=0x130 -> inst_addr stays 0x20 until inst_valid=1, 0x20 word never reaches IF/ID, next inst_addr=0x130.
REQ-033 Stall+redirect same cycle: stall_i=1, redirect_i=1, redirect_pc_i=0x4 -> inst_addr=0x4 next cycle, if_valid_o=0.
REQ-034 Fence: fence_req_i+redirect_i(0x13C) while inst_valid=1 -> fence=1 exactly one cycle, then inst_addr=0x13C, no IF/ID capture during FENCE.
REQ-035 Async reset: drop rst mid-miss with PC=0x134 -> outputs reach REQ-028 values without a clock edge; after release inst_addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the PC into the instruction cache, fills the IF/ID register,
// and handles stalls, redirects (including redirects that arrive during a miss) and fence.i invalidation.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  input  logic        inst_valid,
  output logic        fence,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fence_req_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  // state | meaning
  // RUN   | normal fetch; captures hits into IF/ID
  // DRAIN | redirect arrived during a miss; wait for the refill, then jump to pending_pc
  // FENCE | one-cycle cache invalidate, then jump to pending_pc
  typedef enum logic [1:0] {RUN, DRAIN, FENCE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        fence_pending_q, fence_pending_d;
  logic        fence_q, fence_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic [31:0] drain_tgt;
  logic        drain_fence;

  assign drain_tgt   = redirect_i ? redirect_pc_i : pending_pc_q;
  assign drain_fence = fence_pending_q | (redirect_i & fence_req_i);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_pc_d    = pending_pc_q;
    fence_pending_d = fence_pending_q;
    fence_d         = 1'b0;
    if_valid_d      = if_valid_q;
    if_pc_d         = if_pc_q;
    if_inst_d       = if_inst_q;
    case (state_q)
      RUN: begin
        if (redirect_i) begin
          if_valid_d = 1'b0;
          if (inst_valid) begin
            if (fence_req_i) begin
              pending_pc_d    = redirect_pc_i;
              fence_pending_d = 1'b1;
              fence_d         = 1'b1;
              state_d         = FENCE;
            end else begin
              pc_d = redirect_pc_i;
            end
          end else begin
            pending_pc_d    = redirect_pc_i;
            fence_pending_d = fence_req_i;
            state_d         = DRAIN;
          end
        end else if (!stall_i) begin
          if (inst_valid) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = inst_in;
            pc_d       = pc_q + 32'd4;
          end else begin
            if_valid_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        pending_pc_d    = drain_tgt;
        fence_pending_d = drain_fence;
        if (inst_valid) begin
          // The refilled word belongs to the abandoned path and is dropped.
          // PC stays on the refilled address while fencing so no new miss starts.
          if (drain_fence) begin
            fence_d = 1'b1;
            state_d = FENCE;
          end else begin
            pc_d    = drain_tgt;
            state_d = RUN;
          end
        end
      end
      FENCE: begin
        pc_d            = pending_pc_q;
        fence_pending_d = 1'b0;
        if_valid_d      = 1'b0;
        state_d         = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= RUN;
      pc_q            <= RESET_PC;
      pending_pc_q    <= 32'h0;
      fence_pending_q <= 1'b0;
      fence_q         <= 1'b0;
      if_valid_q      <= 1'b0;
      if_pc_q         <= 32'h0;
      if_inst_q       <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pending_pc_q    <= pending_pc_d;
      fence_pending_q <= fence_pending_d;
      fence_q         <= fence_d;
      if_valid_q      <= if_valid_d;
      if_pc_q         <= if_pc_d;
      if_inst_q       <= if_inst_d;
    end
  end

  assign inst_addr  = pc_q;
  assign fence      = fence_q;
  assign if_valid_o = if_valid_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a fetch-path reference model predicts the PC, fence and
// IF/ID contents; captured instructions are checked by an independent monitor against a queue.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_addr, inst_in, redirect_pc_i, if_pc_o, if_inst_o;
  logic        inst_valid, fence, stall_i, redirect_i, fence_req_i, if_valid_o;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_in(inst_in), .inst_valid(inst_valid),
    .fence(fence), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fence_req_i(fence_req_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [63:0] exp_q[$];

  // reference model state
  logic [31:0] m_pc, m_tgt;
  bit          m_ifv, m_fence, m_drain, m_fp;

  function automatic logic [31:0] mem(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_tgt = 32'h0; m_ifv = 0; m_fence = 0; m_drain = 0; m_fp = 0;
    exp_q.delete();
  endtask

  // Apply one cycle of inputs, advance the model by one clock, then check after the edge.
  task automatic step(bit v, bit st, bit rd, logic [31:0] rpc, bit fr);
    inst_valid = v; inst_in = v ? mem(m_pc) : $urandom;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc; fence_req_i = fr;
    if (m_fence) begin
      m_pc = m_tgt; m_fence = 0; m_fp = 0; m_ifv = 0;
    end else if (m_drain) begin
      if (rd) begin m_tgt = rpc; m_fp = m_fp | fr; end
      if (v) begin
        m_drain = 0;
        if (m_fp) m_fence = 1; else m_pc = m_tgt;
      end
    end else if (rd) begin
      m_ifv = 0; m_tgt = rpc; m_fp = fr;
      if (!v) m_drain = 1;
      else if (fr) m_fence = 1;
      else begin m_pc = rpc; m_fp = 0; end
    end else if (!st) begin
      if (v) begin
        exp_q.push_back({m_pc, mem(m_pc)});
        m_ifv = 1; m_pc = m_pc + 32'd4;
      end else m_ifv = 0;
    end
    @(posedge clk); #1;
    chk("inst_addr", inst_addr, m_pc);
    chk("fence", {31'h0, fence}, {31'h0, m_fence});
    chk("if_valid", {31'h0, if_valid_o}, {31'h0, m_ifv});
  endtask

  // Monitor: a new IF/ID entry is a valid word whose pc differs from the last one seen.
  bit          pv;
  logic [31:0] ppc;
  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (!rst) pv = 0;
    else begin
      if (if_valid_o && (!pv || if_pc_o != ppc)) begin
        if (exp_q.size() == 0) chk("unexpected_capture", if_pc_o, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("cap_pc", if_pc_o, e[63:32]);
          chk("cap_inst", if_inst_o, e[31:0]);
        end
      end
      pv = if_valid_o; ppc = if_pc_o;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 0; #1;
    chk("rst_inst_addr", inst_addr, RST_PC);
    chk("rst_if_valid", {31'h0, if_valid_o}, 32'h0);
    chk("rst_if_pc", if_pc_o, 32'h0);
    chk("rst_if_inst", if_inst_o, 32'h0);
    chk("rst_fence", {31'h0, fence}, 32'h0);
    model_reset();
    @(posedge clk); #1; rst = 1;
  endtask

  initial begin
    inst_valid = 0; inst_in = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0; fence_req_i = 0;
    model_reset();
    do_reset();
    // sequential hits
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    chk("seq_addr", inst_addr, 32'h10);
    chk("seq_if_pc", if_pc_o, 32'hC);
    // miss at 0x10
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    chk("miss_hold", inst_addr, 32'h10);
    step(1, 0, 0, 0, 0);
    chk("miss_done_pc", if_pc_o, 32'h10);
    chk("miss_next", inst_addr, 32'h14);
    // redirect during miss at 0x20
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h130, 0);
    step(0, 0, 0, 0, 0);
    chk("drain_hold", inst_addr, 32'h20);
    step(1, 0, 0, 0, 0);
    chk("drain_target", inst_addr, 32'h130);
    // stall + redirect
    step(1, 1, 1, 32'h4, 0);
    chk("stall_redir", inst_addr, 32'h4);
    // fence
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h13C, 1);
    chk("fence_on", {31'h0, fence}, 32'h1);
    step(1, 0, 0, 0, 0);
    chk("fence_off", {31'h0, fence}, 32'h0);
    chk("fence_target", inst_addr, 32'h13C);
    // fence_req without redirect is ignored
    step(1, 0, 0, 0, 1);
    chk("lone_fence", {31'h0, fence}, 32'h0);
    // wrap past the top of the address space
    step(1, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0, 0);
    chk("wrap", inst_addr, 32'h0);
    // async reset mid-miss at 0x134
    step(1, 0, 1, 32'h134, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst", inst_addr, 32'h134);
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("post_rst", if_pc_o, RST_PC);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, st, rd, fr;
      logic [31:0] rpc;
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 4) == 0);
      rd  = !m_fence && ($urandom_range(0, 7) == 0);
      fr  = !m_fence && ($urandom_range(0, 3) == 0);
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step(v, st, rd, rpc, fr);
    end
    step(1, 0, 0, 0, 0);
    #2;
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
